// File: rtl/change_pkg.sv
// change_pkg: coin and state encodings plus coin values (in nickel units) for change_dispenser
package change_pkg;
    typedef enum logic [1:0] {NICKEL = 2'd0, DIME = 2'd1, QUARTER = 2'd2} coin_t;
    localparam int NICKEL_VAL  = 1;
    localparam int DIME_VAL    = 2;
    localparam int QUARTER_VAL = 5;
    typedef enum logic [1:0] {IDLE, ISSUE, FIN} state_t;
endpackage

// File: rtl/coin_select.sv
// coin_select: greedy largest-coin picker for the amount still owed
// Ports: rem (amount owed), coin_type (picked coin code), value (picked coin value).
// Quarters are only considered when CHANGE_QUARTER_EN is defined.
module coin_select
    import change_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] rem,
    output logic [1:0]   coin_type,
    output logic [W-1:0] value
);
    always_comb begin
`ifdef CHANGE_QUARTER_EN
        coin_type = rem >= W'(QUARTER_VAL) ? QUARTER : rem >= W'(DIME_VAL) ? DIME : NICKEL;
`else
        coin_type = rem >= W'(DIME_VAL) ? DIME : NICKEL;
`endif
        value = coin_type == QUARTER ? W'(QUARTER_VAL) :
                coin_type == DIME    ? W'(DIME_VAL)    : W'(NICKEL_VAL);
    end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out (summ - PRICE) one coin at a time over a valid/ack handshake
// Ports: CLK, reset (sync, active-low), start/summ (payout request), coin_ack (ejector took coin),
//        coin_valid/coin_type (coin presented), busy (not idle), done (payout complete pulse).
// Build option: CHANGE_QUARTER_EN enables quarter payout.
module change_dispenser
    import change_pkg::*;
#(
    parameter int PRICE = 5,
    parameter int W     = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] summ,
    input  logic         coin_ack,
    output logic         coin_valid,
    output logic [1:0]   coin_type,
    output logic         busy,
    output logic         done
);
    state_t       state, state_nxt;
    logic [W-1:0] rem, rem_nxt, coin_val, owed, paid, sel_val;
    logic [1:0]   sel_type;

    assign owed = summ >= W'(PRICE) ? summ - W'(PRICE) : '0;
    // coin_val always matches the presented coin, so this never underflows
    assign paid = rem - coin_val;

    // picks the coin for the amount owed next cycle so the outputs can be registered
    coin_select #(.W(W)) u_sel (
        .rem       (rem_nxt),
        .coin_type (sel_type),
        .value     (sel_val)
    );

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        if (state == IDLE && start) begin
            rem_nxt   = owed;
            state_nxt = owed != '0 ? ISSUE : FIN;
        end else if (state == ISSUE && coin_ack) begin
            rem_nxt   = paid;
            state_nxt = paid != '0 ? ISSUE : FIN;
        end else if (state == FIN) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state      <= IDLE;
            rem        <= '0;
            coin_val   <= '0;
            coin_valid <= 1'b0;
            coin_type  <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            rem        <= rem_nxt;
            coin_val   <= state_nxt == ISSUE ? sel_val : '0;
            coin_valid <= state_nxt == ISSUE;
            coin_type  <= state_nxt == ISSUE ? sel_type : 2'd0;
            busy       <= state_nxt != IDLE;
            done       <= state_nxt == FIN;
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed scoreboard bench for change_dispenser
module tb_change_dispenser;
    localparam int PRICE = 5;
    localparam int W     = 4;

    logic         CLK = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] summ = '0;
    logic         coin_ack = 1'b0;
    logic         coin_valid, busy, done;
    logic [1:0]   coin_type;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] sb[$];

    change_dispenser #(.PRICE(PRICE), .W(W)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .start      (start),
        .summ       (summ),
        .coin_ack   (coin_ack),
        .coin_valid (coin_valid),
        .coin_type  (coin_type),
        .busy       (busy),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_model(input int s, output int n);
        int r;
        r = s >= PRICE ? s - PRICE : 0;
        n = 0;
        while (r > 0) begin
`ifdef CHANGE_QUARTER_EN
            if (r >= 5) begin
                sb.push_back(2'd2);
                r -= 5;
            end else
`endif
            if (r >= 2) begin
                sb.push_back(2'd1);
                r -= 2;
            end else begin
                sb.push_back(2'd0);
                r -= 1;
            end
            n++;
        end
    endtask

    task automatic pay(input int s, input int stall, input bit restart);
        int n, cyc, left;
        @(negedge CLK);
        sb.delete();
        push_model(s, n);
        start = 1'b1;
        summ  = W'(s);
        @(negedge CLK);
        start = 1'b0;
        cyc   = 1;
        left  = stall;
        while (!done && cyc < 200) begin
            chk("busy", busy, 1);
            chk("valid", coin_valid, sb.size() > 0);
            if (coin_valid && sb.size() > 0) begin
                chk("type", coin_type, sb[0]);
                if (left > 0) begin
                    left--;
                    coin_ack = 1'b0;
                end else begin
                    void'(sb.pop_front());
                    coin_ack = 1'b1;
                end
            end
            if (restart && cyc == 1) begin
                start = 1'b1;
                summ  = 4'd15;
            end
            @(negedge CLK);
            start = 1'b0;
            cyc++;
        end
        coin_ack = 1'b0;
        chk("done", done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", coin_valid, 0);
        chk("cycles", cyc, n + 1 + stall);
        chk("sb_empty", sb.size(), 0);
        @(negedge CLK);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_valid", coin_valid, 0);
        chk("rst_type", coin_type, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        pay(8, 0, 1'b0);
        pay(15, 0, 1'b0);
        pay(5, 0, 1'b0);
        pay(3, 0, 1'b0);
        pay(9, 6, 1'b0);
        pay(8, 0, 1'b1);
        @(negedge CLK);
        start = 1'b1;
        summ  = 4'd8;
        @(negedge CLK);
        start = 1'b0;
        chk("abort_first", coin_type, 1);
        coin_ack = 1'b1;
        @(negedge CLK);
        coin_ack = 1'b0;
        chk("abort_second_valid", coin_valid, 1);
        reset = 1'b0;
        @(negedge CLK);
        chk("abort_valid", coin_valid, 0);
        chk("abort_type", coin_type, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        reset = 1'b1;
        @(negedge CLK);
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);
        pay(8, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
